credit_link_pipe: RTL

//  Multi-channel credit-based latency-insensitive link between two pearls.

---
 rtl/credit_link_pkg.sv | 15 +
 rtl/credit_link_counter.sv | 67 ++++++
 rtl/credit_link_pipe.sv | 73 +++++++
 3 files changed

// File: rtl/credit_link_pkg.sv
// Shared helpers for credit_link_pipe: counter width function, stall counter width,
// and CREDIT_LINK_STAGE_T(W), which builds the packed valid+data type of one pipe stage.
`ifndef CREDIT_LINK_PKG_SV
`define CREDIT_LINK_PKG_SV
`define CREDIT_LINK_STAGE_T(W) struct packed { logic valid; logic [(W)-1:0] data; }

package credit_link_pkg;
  localparam int STALL_W = 32;

  function automatic int cnt_w(input int credits);
    return $clog2(credits + 1);
  endfunction
endpackage

`endif

// File: rtl/credit_link_counter.sv
// One channel's sender-side credit counter with a sticky overflow flag.
// When CREDIT_LINK_STATS_EN is defined, a saturating stall-cycle counter is also built.
module credit_link_counter
  import credit_link_pkg::*;
#(
  parameter int INIT_CREDITS = 4,
  localparam int CNT_W = cnt_w(INIT_CREDITS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_valid,
  input  logic               i_credit_ret,
  output logic               o_ready,
  output logic               o_accept,
  output logic [CNT_W-1:0]   o_credit_count,
  output logic               o_credit_err,
  output logic [STALL_W-1:0] o_stall_count
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(INIT_CREDITS);

  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_reg, err_next;

  assign o_ready        = (count_reg != '0);
  assign o_accept       = i_valid & o_ready;
  assign o_credit_count = count_reg;
  assign o_credit_err   = err_reg;

  // A credit returned while already full means the consumer popped more than it received.
  always_comb begin
    count_next = count_reg;
    err_next   = err_reg;
    if (o_accept && !i_credit_ret) begin
      count_next = count_reg - CNT_W'(1);
    end else if (!o_accept && i_credit_ret) begin
      if (count_reg == FULL) err_next = 1'b1;
      else                   count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= FULL;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

`ifdef CREDIT_LINK_STATS_EN
  logic [STALL_W-1:0] stall_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_reg <= '0;
    end else if (i_valid && !o_ready && stall_reg != '1) begin
      stall_reg <= stall_reg + STALL_W'(1);
    end
  end

  assign o_stall_count = stall_reg;
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: rtl/credit_link_pipe.sv
// Multi-channel credit-based link: forward data pipe, equal-depth credit-return pipe and
// per-channel credit counters. Stall statistics are built when CREDIT_LINK_STATS_EN is defined.
module credit_link_pipe
  import credit_link_pkg::*;
#(
  parameter int DATA_WIDTH   = 17,
  parameter int N_CHANNELS   = 2,
  parameter int N_STAGES     = 1,
  parameter int INIT_CREDITS = 4,
  localparam int CNT_W = cnt_w(INIT_CREDITS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] i_data,
  input  logic [N_CHANNELS-1:0]            i_valid,
  output logic [N_CHANNELS-1:0]            o_ready,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] o_data,
  output logic [N_CHANNELS-1:0]            o_valid,
  input  logic [N_CHANNELS-1:0]            i_increment_count,
  output logic [N_CHANNELS*CNT_W-1:0]      o_credit_count,
  output logic [N_CHANNELS-1:0]            o_credit_err,
  output logic [N_CHANNELS*STALL_W-1:0]    o_stall_count
);
  typedef `CREDIT_LINK_STAGE_T(DATA_WIDTH) stage_t;

  logic [N_CHANNELS-1:0] accept;
  logic [N_CHANNELS-1:0] credit_ret;

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
    credit_link_counter #(
      .INIT_CREDITS(INIT_CREDITS)
    ) u_counter (
      .clock          (clock),
      .reset          (reset),
      .i_valid        (i_valid[gi]),
      .i_credit_ret   (credit_ret[gi]),
      .o_ready        (o_ready[gi]),
      .o_accept       (accept[gi]),
      .o_credit_count (o_credit_count[gi*CNT_W +: CNT_W]),
      .o_credit_err   (o_credit_err[gi]),
      .o_stall_count  (o_stall_count[gi*STALL_W +: STALL_W])
    );

    if (N_STAGES == 0) begin : g_comb
      assign o_valid[gi]                           = accept[gi];
      assign o_data[gi*DATA_WIDTH +: DATA_WIDTH]   = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign credit_ret[gi]                        = i_increment_count[gi];
    end else begin : g_pipe
      stage_t              fwd_reg [N_STAGES];
      logic [N_STAGES-1:0] ret_reg;

      // Non-accepted cycles inject an empty stage so latency stays exactly N_STAGES.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < N_STAGES; i++) fwd_reg[i] <= '0;
          ret_reg <= '0;
        end else begin
          fwd_reg[0] <= '{valid: accept[gi], data: i_data[gi*DATA_WIDTH +: DATA_WIDTH]};
          ret_reg[0] <= i_increment_count[gi];
          for (int i = 1; i < N_STAGES; i++) begin
            fwd_reg[i] <= fwd_reg[i-1];
            ret_reg[i] <= ret_reg[i-1];
          end
        end
      end

      assign o_valid[gi]                         = fwd_reg[N_STAGES-1].valid;
      assign o_data[gi*DATA_WIDTH +: DATA_WIDTH] = fwd_reg[N_STAGES-1].data;
      assign credit_ret[gi]                      = ret_reg[N_STAGES-1];
    end
  end

endmodule
